// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM states, per-player
// result codes and the hold-off LFSR definition.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_HOLDOFF   = 3'd2,
        ST_GO        = 3'd3,
        ST_RESULT    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PL_PENDING = 2'd0,
        PL_VALID   = 2'd1,
        PL_FALSE   = 2'd2,
        PL_TIMEOUT = 2'd3
    } pl_status_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_core_if.sv
// Control inputs and result outputs of the reaction timer, grouped so the
// display/sequencing side connects through one port.
interface reaction_timer_core_if #(parameter int PLAYERS = 2);
    logic                    start;
    logic                    abort;
    logic [PLAYERS-1:0]      button;
    logic [2:0]              state_o;
    logic [3:0]              countdown_sec;
    logic                    go;
    logic [14*PLAYERS-1:0]   time_ms;
    logic [2*PLAYERS-1:0]    status;
    logic [2:0]              winner;
    logic                    winner_valid;
    logic                    done;

    modport master (
        output start, abort, button,
        input  state_o, countdown_sec, go, time_ms, status, winner, winner_valid, done
    );

    modport slave (
        input  start, abort, button,
        output state_o, countdown_sec, go, time_ms, status, winner, winner_valid, done
    );
endinterface

// File: rtl/reaction_ms_tick.sv
// Millisecond prescaler: one-cycle tick every DIV cycles, restartable by clear.
module reaction_ms_tick #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Tick must not depend on clear: a tick is what causes many state changes.
    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/reaction_timer_core.sv
// Multi-player reaction timing engine: countdown, random hold-off, GO window,
// per-player timestamps and winner resolution.
//
//   state        | meaning
//   -------------+---------------------------------------------------
//   ST_IDLE      | waiting for start, results cleared
//   ST_COUNTDOWN | seconds countdown, presses are false starts
//   ST_HOLDOFF   | fixed + random ms delay, presses are false starts
//   ST_GO        | go lit, first press per player is timestamped
//   ST_RESULT    | results and winner held until start/abort
module reaction_timer_core
    import reaction_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int PLAYERS        = 2,
    parameter int COUNTDOWN_S    = 3,
    parameter int HOLD_MIN_MS    = 1000,
    parameter int HOLD_RAND_BITS = 10,
    parameter int MAX_MS         = 9999
) (
    input  logic                  clk,
    input  logic                  reset_n,
    reaction_timer_core_if.slave  bus
);
    localparam int MSW = 17;
    localparam logic [15:0] HOLD_MASK = 16'((32'd1 << HOLD_RAND_BITS) - 32'd1);

    state_e                 state_q, state_nxt;
    logic [15:0]            lfsr_q;
    logic [MSW-1:0]         ms_q, hold_q;
    logic [3:0]             sec_q;
    logic                   tick, entering, clear_res, in_round;
    logic                   sec_tick, hold_done, go_timeout;
    logic                   done_q, winner_valid_q;
    logic [2:0]             winner_q;
    logic [PLAYERS-1:0]     pend_nxt, false_nxt, valid_nxt;
    logic [14*PLAYERS-1:0]  time_nxt, time_flat;
    logic [2*PLAYERS-1:0]   status_flat;
    logic [2:0]             win_idx;
    logic                   win_any;
    logic [13:0]            win_time;

    reaction_ms_tick #(.DIV(CLK_HZ / 1000)) u_ms_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (entering),
        .tick    (tick)
    );

    assign entering   = (state_nxt != state_q);
    assign clear_res  = bus.abort || (bus.start && (state_q == ST_IDLE || state_q == ST_RESULT));
    assign in_round   = (state_q == ST_COUNTDOWN) || (state_q == ST_HOLDOFF) || (state_q == ST_GO);
    assign sec_tick   = tick && (state_q == ST_COUNTDOWN) && (ms_q == MSW'(999));
    assign hold_done  = tick && (ms_q + MSW'(1) == hold_q);
    assign go_timeout = tick && (ms_q == MSW'(MAX_MS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (bus.abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (bus.start) state_nxt = ST_COUNTDOWN;
                ST_COUNTDOWN: if (&false_nxt) state_nxt = ST_RESULT;
                              else if (sec_tick && sec_q == 4'd1) state_nxt = ST_HOLDOFF;
                ST_HOLDOFF:   if (&false_nxt) state_nxt = ST_RESULT;
                              else if (hold_done) state_nxt = ST_GO;
                ST_GO:        if (~|pend_nxt) state_nxt = ST_RESULT;
                ST_RESULT:    if (bus.start) state_nxt = ST_COUNTDOWN;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
            ms_q   <= '0;
            hold_q <= '0;
            sec_q  <= '0;
            done_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            done_q <= entering && (state_nxt == ST_RESULT);
            // Countdown reuses the ms counter as a 0..999 sub-second counter
            if (entering) begin
                ms_q <= '0;
            end else if (tick && in_round) begin
                ms_q <= sec_tick ? '0 : ms_q + MSW'(1);
            end
            if (entering && state_nxt == ST_HOLDOFF) begin
                hold_q <= MSW'(HOLD_MIN_MS) + MSW'(lfsr_q & HOLD_MASK);
            end
            if (state_nxt != ST_COUNTDOWN) begin
                sec_q <= '0;
            end else if (state_q != ST_COUNTDOWN) begin
                sec_q <= 4'(COUNTDOWN_S);
            end else if (sec_tick) begin
                sec_q <= sec_q - 4'd1;
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        pl_status_e  stat_q, stat_d;
        logic [13:0] time_q, time_d;

        always_comb begin
            stat_d = stat_q;
            time_d = time_q;
            if (clear_res) begin
                stat_d = PL_PENDING;
                time_d = '0;
            end else if (in_round && stat_q == PL_PENDING) begin
                if (bus.button[p]) begin
                    if (state_q == ST_GO) begin
                        stat_d = PL_VALID;
                        time_d = ms_q[13:0];
                    end else begin
                        stat_d = PL_FALSE;
                    end
                end else if (state_q == ST_GO && go_timeout) begin
                    stat_d = PL_TIMEOUT;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stat_q <= PL_PENDING;
                time_q <= '0;
            end else begin
                stat_q <= stat_d;
                time_q <= time_d;
            end
        end

        assign pend_nxt[p]            = (stat_d == PL_PENDING);
        assign false_nxt[p]           = (stat_d == PL_FALSE);
        assign valid_nxt[p]           = (stat_d == PL_VALID);
        assign time_nxt[14*p +: 14]   = time_d;
        assign time_flat[14*p +: 14]  = time_q;
        assign status_flat[2*p +: 2]  = stat_q;
    end

    // Strict less-than keeps the lowest index on ties
    always_comb begin
        win_idx  = '0;
        win_any  = 1'b0;
        win_time = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (valid_nxt[p] && (!win_any || time_nxt[14*p +: 14] < win_time)) begin
                win_any  = 1'b1;
                win_idx  = 3'(p);
                win_time = time_nxt[14*p +: 14];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else if (clear_res) begin
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else if (entering && state_nxt == ST_RESULT) begin
            winner_q       <= win_idx;
            winner_valid_q <= win_any;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.countdown_sec = sec_q;
    assign bus.go            = (state_q == ST_GO);
    assign bus.time_ms       = time_flat;
    assign bus.status        = status_flat;
    assign bus.winner        = winner_q;
    assign bus.winner_valid  = winner_valid_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core at CLK_HZ=4000 (4 cycles per ms).
module tb_reaction_timer_core;
    import reaction_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    reaction_timer_core_if #(.PLAYERS(2)) bus ();
    reaction_timer_core_if #(.PLAYERS(2)) bus_r ();

    reaction_timer_core #(
        .CLK_HZ(4000), .PLAYERS(2), .COUNTDOWN_S(1), .HOLD_MIN_MS(5),
        .HOLD_RAND_BITS(0), .MAX_MS(50)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    reaction_timer_core #(
        .CLK_HZ(4000), .PLAYERS(2), .COUNTDOWN_S(1), .HOLD_MIN_MS(5),
        .HOLD_RAND_BITS(10), .MAX_MS(50)
    ) dut_r (
        .clk(clk), .reset_n(reset_n), .bus(bus_r.slave)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11, shifting left, seeded at reset
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= 16'hACE1;
        else          lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    always @(negedge clk) if (bus.done) done_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic press(input logic [1:0] mask);
        bus.button = mask;
        @(negedge clk);
        bus.button = 2'b00;
    endtask

    function automatic logic [41:0] all_outs();
        return {bus.time_ms, bus.status, bus.winner, bus.winner_valid, bus.done, bus.go, bus.countdown_sec};
    endfunction

    // From IDLE/RESULT to the first cycle of GO with no presses
    task automatic to_go(input string tag);
        pulse_start();
        chk({tag, "_cd_state"}, bus.state_o, ST_COUNTDOWN);
        chk({tag, "_cd_sec"}, bus.countdown_sec, 4'd1);
        chk({tag, "_cd_clear"}, {bus.time_ms, bus.status, bus.winner, bus.winner_valid}, 0);
        wait_cyc(3999);
        chk({tag, "_cd_last"}, {bus.state_o, bus.countdown_sec}, {ST_COUNTDOWN, 4'd1});
        wait_cyc(1);
        chk({tag, "_ho_entry"}, {bus.state_o, bus.countdown_sec}, {ST_HOLDOFF, 4'd0});
        wait_cyc(19);
        chk({tag, "_ho_last"}, {bus.state_o, bus.go}, {ST_HOLDOFF, 1'b0});
        wait_cyc(1);
        chk({tag, "_go_entry"}, {bus.state_o, bus.go}, {ST_GO, 1'b1});
    endtask

    initial begin
        int done_base;
        int hold_exp;
        bus.start = 0; bus.abort = 0; bus.button = 0;
        bus_r.start = 0; bus_r.abort = 0; bus_r.button = 0;
        wait_cyc(3);
        chk("rst_state", bus.state_o, ST_IDLE);
        chk("rst_outs", all_outs(), 0);
        reset_n = 1'b1;
        wait_cyc(2);

        // Scenario 1: p1 at 12 ms, p0 times out
        to_go("s1");
        done_base = done_cnt;
        wait_cyc(48);
        press(2'b10);
        chk("s1_p1_valid", bus.status, 4'b0100);
        chk("s1_p1_time", bus.time_ms[27:14], 14'd12);
        wait_cyc(150);
        chk("s1_pre_timeout", bus.state_o, ST_GO);
        wait_cyc(1);
        chk("s1_result", {bus.state_o, bus.done}, {ST_RESULT, 1'b1});
        chk("s1_status", bus.status, 4'b0111);
        chk("s1_winner", {bus.winner, bus.winner_valid}, {3'd1, 1'b1});
        chk("s1_times", bus.time_ms, {14'd12, 14'd0});
        wait_cyc(1);
        chk("s1_done_drop", {bus.state_o, bus.done}, {ST_RESULT, 1'b0});
        chk("s1_done_once", done_cnt - done_base, 1);

        // Scenarios 6 and 3: new round clears, start ignored in GO, tie at 7 ms
        to_go("s6");
        wait_cyc(10);
        pulse_start();
        chk("s6_start_in_go", {bus.state_o, bus.status}, {ST_GO, 4'b0000});
        wait_cyc(17);
        press(2'b11);
        chk("s3_result", {bus.state_o, bus.done}, {ST_RESULT, 1'b1});
        chk("s3_status", bus.status, 4'b0101);
        chk("s3_times", bus.time_ms, {14'd7, 14'd7});
        chk("s3_winner", {bus.winner, bus.winner_valid}, {3'd0, 1'b1});

        // Scenario 2: p0 false start in countdown, p1 at 3 ms ends the round
        pulse_start();
        wait_cyc(100);
        press(2'b01);
        chk("s2_false", {bus.state_o, bus.status}, {ST_COUNTDOWN, 4'b0010});
        wait_cyc(3899);
        chk("s2_ho", bus.state_o, ST_HOLDOFF);
        wait_cyc(20);
        chk("s2_go", bus.state_o, ST_GO);
        wait_cyc(12);
        press(2'b10);
        chk("s2_result", {bus.state_o, bus.done}, {ST_RESULT, 1'b1});
        chk("s2_status", bus.status, 4'b0110);
        chk("s2_time", bus.time_ms, {14'd3, 14'd0});
        chk("s2_winner", {bus.winner, bus.winner_valid}, {3'd1, 1'b1});

        // Boundaries: press on the HOLDOFF->GO edge, press on the MAX_MS tick
        pulse_start();
        wait_cyc(4019);
        press(2'b01);
        chk("edge_ho_go", {bus.state_o, bus.status}, {ST_GO, 4'b0010});
        wait_cyc(198);
        press(2'b10);
        chk("edge_max_result", {bus.state_o, bus.status}, {ST_RESULT, 4'b0110});
        chk("edge_max_time", bus.time_ms, {14'd49, 14'd0});
        chk("edge_max_winner", {bus.winner, bus.winner_valid}, {3'd1, 1'b1});

        // Scenario 4: both false in HOLDOFF
        pulse_start();
        wait_cyc(4000);
        chk("s4_ho", bus.state_o, ST_HOLDOFF);
        wait_cyc(10);
        press(2'b11);
        chk("s4_result", {bus.state_o, bus.done, bus.status}, {ST_RESULT, 1'b1, 4'b1010});
        chk("s4_winner", {bus.winner, bus.winner_valid}, 0);

        // Scenario 5: abort mid-GO, abort beats start, reset mid-countdown
        pulse_start();
        wait_cyc(4050);
        chk("s5_in_go", bus.state_o, ST_GO);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("s5_abort_state", bus.state_o, ST_IDLE);
        chk("s5_abort_outs", all_outs(), 0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("s5_abort_prio", bus.state_o, ST_IDLE);
        pulse_start();
        wait_cyc(50);
        chk("s5_cd", bus.state_o, ST_COUNTDOWN);
        reset_n = 1'b0;
        #1;
        chk("s5_reset_state", bus.state_o, ST_IDLE);
        chk("s5_reset_outs", all_outs(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(7);

        // Random hold-off against the reference LFSR
        bus_r.start = 1'b1;
        @(negedge clk);
        bus_r.start = 1'b0;
        chk("s5r_cd", bus_r.state_o, ST_COUNTDOWN);
        wait_cyc(3999);
        hold_exp = 5 + int'(lfsr_m & 16'h03FF);
        wait_cyc(1);
        chk("s5r_ho_entry", bus_r.state_o, ST_HOLDOFF);
        wait_cyc(hold_exp * 4 - 1);
        chk("s5r_ho_last", bus_r.state_o, ST_HOLDOFF);
        wait_cyc(1);
        chk("s5r_go", {bus_r.state_o, bus_r.go}, {ST_GO, 1'b1});
        bus_r.abort = 1'b1;
        @(negedge clk);
        bus_r.abort = 1'b0;
        chk("s5r_abort", bus_r.state_o, ST_IDLE);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/reaction_timer_core.md
# reaction_timer_core

Parametrised multi-player reaction-timing engine, the next generation of the board-level reaction game. It runs a seconds countdown, then a pseudo-random hold-off, then asserts GO. It timestamps each player's first press in milliseconds and flags false starts and timeouts per player. The result is resolved to a winner index. It sits between the synchronised/debounced KEY inputs and the seven-segment/LED display logic, which consume its binary results.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency; must be a multiple of 1000.
- `PLAYERS`, 2, number of player buttons, 1..8.
- `COUNTDOWN_S`, 3, countdown length in seconds, 1..9.
- `HOLD_MIN_MS`, 1000, fixed part of the hold-off after the countdown.
- `HOLD_RAND_BITS`, 10, random hold-off width; adds 0..2^N-1 ms; 0 makes the hold-off deterministic.
- `MAX_MS`, 9999, reaction window in ms; must be ≤ 16383.
- `clk`  in  1  single clock, all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a round; accepted only in IDLE or RESULT.
- `abort`  in  1  return to IDLE from any state; takes priority over `start`.
- `button`  in  PLAYERS  player presses, active-high, already synchronised.
- `state_o`  out  3  current state encoding (package enum).
- `countdown_sec`  out  4  seconds remaining in COUNTDOWN, else 0.
- `go`  out  1  high in GO only.
- `time_ms`  out  14*PLAYERS  per-player reaction time, player p at bits [14p+13:14p].
- `status`  out  2*PLAYERS  per-player status: PENDING=0, VALID=1, FALSE=2, TIMEOUT=3.
- `winner`  out  3  index of the fastest VALID player.
- `winner_valid`  out  1  at least one VALID player.
- `done`  out  1  one-cycle pulse on entry to RESULT.

## Operation
- States: IDLE, COUNTDOWN, HOLDOFF, GO, RESULT.
- IDLE → COUNTDOWN on `start`. Entry clears all `time_ms` and `status` to 0 and clears the ms counter.
- COUNTDOWN: `countdown_sec` starts at COUNTDOWN_S and decrements every 1000 ms ticks. After the tick that takes it from 1 to 0, the block enters HOLDOFF.
- HOLDOFF length = HOLD_MIN_MS + (lfsr[HOLD_RAND_BITS-1:0]), latched on HOLDOFF entry. When the elapsed ms equals this length, the block enters GO.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset, advances every cycle in every state.
- A press in COUNTDOWN or HOLDOFF by a PENDING player sets that player's status to FALSE. The round continues for the others. If all players are FALSE, the block goes directly to RESULT.
- GO: the ms counter restarts at 0 on entry. A PENDING player whose button is high in a cycle records `time_ms` = current ms count and status VALID. Later presses by that player are ignored.
- When the ms count reaches MAX_MS, remaining PENDING players become TIMEOUT and the block enters RESULT. The block also enters RESULT once no player is PENDING.
- RESULT: outputs are held. `start` begins a new round; `abort` goes to IDLE.
- Winner: the smallest `time_ms` among VALID players; ties go to the lowest index. `winner` = 0 and `winner_valid` = 0 if there is no VALID player. Both are registered on RESULT entry.
- `abort` in any state: go to IDLE and clear all results; the LFSR is not reset.

## Timing
- Reset values: state IDLE; all outputs 0; LFSR = 16'hACE1; prescaler and ms counter = 0.
- ms tick: one-cycle pulse every CLK_HZ/1000 cycles. The prescaler is cleared on every state entry, so the first tick comes CLK_HZ/1000 cycles after entry.
- Press latency: a press sampled at edge n appears in `status`/`time_ms` after edge n (registered, 1 cycle).
- A press in the same cycle as the transition HOLDOFF→GO is a false start, because the state is still HOLDOFF.
- A press in the same cycle as the MAX_MS tick is VALID with `time_ms` = MAX_MS-1.
- Simultaneous presses in one cycle are all recorded; the tie rule decides the winner.
- `done` is asserted in the first cycle of RESULT.

## Structure
- The package `reaction_pkg` holds the state enum, the player status enum, and the LFSR seed/taps constants.
- Sub-module `reaction_ms_tick` is a prescaler with synchronous clear that produces the ms tick.
- The per-player logic is a generate loop.

## Test plan
All scenarios use CLK_HZ=4000, PLAYERS=2, COUNTDOWN_S=1, HOLD_MIN_MS=5, HOLD_RAND_BITS=0, MAX_MS=50.

1. `start`, then player 1 presses 12 ms into GO and player 0 never presses → `status` = {VALID, TIMEOUT} at MAX_MS; `winner`=1; `time_ms[1]`=12; `done` pulses once.
2. Player 0 presses during COUNTDOWN → status0=FALSE. Player 1 presses at 3 ms into GO → `winner`=1; RESULT is entered at that press.
3. Both players press in the same GO cycle at 7 ms → both VALID with 7; `winner`=0.
4. Both players press during HOLDOFF → both FALSE; RESULT immediately; `winner_valid`=0.
5. `abort` mid-GO, then `reset_n` low mid-COUNTDOWN → IDLE with all outputs 0. After reset, the LFSR equals the seed; with HOLD_RAND_BITS=10, the first hold-off is checked against a model.
6. `start` is ignored in GO; `start` in RESULT begins a new round with cleared results; `countdown_sec` sequence is 1→0 at the 1000th tick.
